argmax_classifier: RTL and testbench

//  Final classification stage downstream of the fc2 fully-connected layer.
//  On fc2's done pulse, snapshots the NUM_CLASSES quantised scores.

---
 rtl/argmax_classifier.sv | 88 ++++++++
 tb/tb_argmax_classifier.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - serial signed argmax over a snapshotted score vector
// Ties keep the lowest class index; results hold until the next completed scan.
module argmax_classifier #(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_CLASSES = 10,
   parameter int IDX_WIDTH   = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores,
   output logic                              busy,
   output logic                              result_valid,
   output logic [IDX_WIDTH-1:0]              class_idx,
   output logic [DATA_WIDTH-1:0]             class_score,
   output logic                              overrun
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

   state_t                        state;
   logic signed [DATA_WIDTH-1:0]  snap [NUM_CLASSES];
   logic signed [DATA_WIDTH-1:0]  best_val;
   logic [IDX_WIDTH-1:0]          best_idx;
   logic [IDX_WIDTH-1:0]          ptr;

   logic signed [DATA_WIDTH-1:0]  cand_val;
   logic                          take_cand;
   logic signed [DATA_WIDTH-1:0]  nxt_val;
   logic [IDX_WIDTH-1:0]          nxt_idx;

   // Strictly-greater replace keeps the earliest index on ties.
   always_comb begin
      cand_val  = snap[ptr];
      take_cand = cand_val > best_val;
      nxt_val   = take_cand ? cand_val : best_val;
      nxt_idx   = take_cand ? ptr : best_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         class_idx    <= '0;
         class_score  <= '0;
         overrun      <= 1'b0;
         best_val     <= '0;
         best_idx     <= '0;
         ptr          <= '0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  for (int j = 0; j < NUM_CLASSES; j++)
                     snap[j] <= scores[DATA_WIDTH*j +: DATA_WIDTH];
                  best_val <= scores[DATA_WIDTH-1:0];
                  best_idx <= '0;
                  ptr      <= IDX_WIDTH'(1);
                  busy     <= 1'b1;
                  state    <= SCAN;
               end else begin
                  state <= IDLE;
               end
            end
            SCAN: begin
               if (start)
                  overrun <= 1'b1;
               best_val <= nxt_val;
               best_idx <= nxt_idx;
               ptr      <= ptr + IDX_WIDTH'(1);
               if (ptr == LAST_IDX) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  result_valid <= 1'b1;
                  class_idx    <= nxt_idx;
                  class_score  <= nxt_val;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - directed bench with a cycle-level argmax model
// The model counts busy cycles and computes argmax on the accepted scores.
module tb_argmax_classifier;

   localparam int DW = 8;
   localparam int NC = 10;
   localparam int IW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [NC*DW-1:0]  scores;
   logic              busy;
   logic              result_valid;
   logic [IW-1:0]     class_idx;
   logic [DW-1:0]     class_score;
   logic              overrun;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int base = 0;
   bit chk_en = 1'b0;

   argmax_classifier #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .start(start), .scores(scores), .busy(busy),
      .result_valid(result_valid), .class_idx(class_idx),
      .class_score(class_score), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model
   int            m_left = 0;
   bit            m_valid = 0, m_over = 0;
   int            m_idx = 0, p_idx = 0;
   logic [DW-1:0] m_score = '0, p_score = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_left = 0; m_valid = 0; m_idx = 0; m_score = '0; m_over = 0;
      end else begin
         m_valid = 0;
         if (m_left > 0) begin
            if (start) m_over = 1;
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_valid = 1; m_idx = p_idx; m_score = p_score;
            end
         end else if (start) begin
            p_idx = 0;
            p_score = scores[DW-1:0];
            for (int j = 1; j < NC; j++)
               if ($signed(scores[DW*j +: DW]) > $signed(p_score)) begin
                  p_idx = j; p_score = scores[DW*j +: DW];
               end
            m_left = NC - 1;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc - base, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",         int'(busy),         int'(m_left > 0));
         check("result_valid", int'(result_valid), int'(m_valid));
         check("class_idx",    int'(class_idx),    m_idx);
         check("class_score",  int'(class_score),  int'(m_score));
         check("overrun",      int'(overrun),      int'(m_over));
      end
   end

   task automatic at(input int c);
      int guard = 0;
      while (cyc < base + c && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      #1;
   endtask

   task automatic set_all(input logic [DW-1:0] v);
      for (int j = 0; j < NC; j++) scores[DW*j +: DW] = v;
   endtask

   task automatic mark;
      @(negedge clk);
      base = cyc;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; scores = '0;
      // T1 reset
      @(posedge clk); #1; chk_en = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      check("t1_busy", int'(busy), 0);
      check("t1_valid", int'(result_valid), 0);
      check("t1_idx", int'(class_idx), 0);
      check("t1_score", int'(class_score), 0);
      check("t1_overrun", int'(overrun), 0);
      rst = 1'b0;

      // T2 basic
      mark(); set_all(8'd1); scores[DW*9 +: DW] = 8'd5; scores[DW*7 +: DW] = 8'd40;
      start = 1'b1;
      at(1); start = 1'b0;
      check("t2_busy_c1", int'(busy), 1);
      at(9);  check("t2_busy_c9", int'(busy), 1);
              check("t2_novalid_c9", int'(result_valid), 0);
      at(10); check("t2_valid", int'(result_valid), 1);
              check("t2_busy_c10", int'(busy), 0);
              check("t2_idx", int'(class_idx), 7);
              check("t2_score", int'(class_score), 40);
              check("t2_model_idx", m_idx, 7);
      at(11); check("t2_valid_drop", int'(result_valid), 0);
              check("t2_idx_hold", int'(class_idx), 7);

      // T3 signed and ties
      mark(); set_all(8'hF0); scores[DW*3 +: DW] = 8'hFE; scores[DW*6 +: DW] = 8'hFE;
      start = 1'b1;
      at(1); start = 1'b0;
      at(10); check("t3_valid", int'(result_valid), 1);
              check("t3_idx", int'(class_idx), 3);
              check("t3_score", int'(class_score), 'hFE);
      at(12);
      mark(); set_all(8'h80); start = 1'b1;
      at(1); start = 1'b0;
      at(10); check("t3_min_idx", int'(class_idx), 0);
              check("t3_min_score", int'(class_score), 'h80);
      at(12);

      // T4 snapshot isolation
      mark(); set_all(8'd3); scores[DW*4 +: DW] = 8'd20; start = 1'b1;
      at(1); start = 1'b0; scores[DW*2 +: DW] = 8'h7F;
      at(10); check("t4_idx", int'(class_idx), 4);
              check("t4_score", int'(class_score), 20);
              check("t4_model_score", int'(m_score), 20);
      at(12);

      // T5 overrun then back-to-back from DONE
      mark(); set_all(8'h05); scores[DW*8 +: DW] = 8'h7F; start = 1'b1;
      at(1); start = 1'b0;
      at(4); start = 1'b1; scores[DW*1 +: DW] = 8'h60;
      at(5); start = 1'b0;
      check("t5_overrun", int'(overrun), 1);
      at(10); check("t5_valid", int'(result_valid), 1);
              check("t5_idx", int'(class_idx), 8);
              start = 1'b1; set_all(8'h10); scores[DW*9 +: DW] = 8'h11;
      at(11); start = 1'b0;
              check("t5_busy_again", int'(busy), 1);
      at(20); check("t5_valid2", int'(result_valid), 1);
              check("t5_idx2", int'(class_idx), 9);
              check("t5_overrun_hold", int'(overrun), 1);
      at(22);

      // T6 reset mid-scan
      mark(); set_all(8'h22); scores[DW*5 +: DW] = 8'h30; start = 1'b1;
      at(1); start = 1'b0;
      at(5); rst = 1'b1;
      at(6); rst = 1'b0;
      check("t6_busy", int'(busy), 0);
      check("t6_idx", int'(class_idx), 0);
      check("t6_score", int'(class_score), 0);
      check("t6_overrun", int'(overrun), 0);
      at(7); start = 1'b1;
      at(8); start = 1'b0;
      at(16); check("t6_novalid_c16", int'(result_valid), 0);
      at(17); check("t6_valid", int'(result_valid), 1);
              check("t6_idx_new", int'(class_idx), 5);
              check("t6_score_new", int'(class_score), 'h30);
      at(20);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

endmodule
